gb80_register_file_paired: RTL
==============================

# gb80_register_file_paired

Parametrised successor to the gb80 8-bit register file: a bank of NUM_REGS byte registers with two independent zero-when-idle read ports for the OR-combined data bus, one byte write port, and a 16-bit pair port with an integrated post-increment/decrement/load unit. It drives the memory address from a selected register pair (HL+/HL-, BC, DE style) and removes the external 16-bit adder from the registers section.

## Interface
- DATA_WIDTH, 8: byte register width; pair width is 2*DATA_WIDTH.
- ADDR_WIDTH, 3: byte address width.
- NUM_REGS, 8: implemented registers; even, 2..2^ADDR_WIDTH.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  byte write enable.
- i_wr_addr  in  ADDR_WIDTH  byte write address.
- i_data  in  DATA_WIDTH  byte write data (from data bus).
- i_rd_en_a / i_rd_en_b  in  1  read enables, ports A/B.
- i_rd_addr_a / i_rd_addr_b  in  ADDR_WIDTH  read addresses.
- o_data_a / o_data_b  out  DATA_WIDTH  read data; all zeros when disabled.
- i_pair_sel  in  ADDR_WIDTH-1  pair index k: high byte = reg 2k, low byte = reg 2k+1.
- i_pair_op  in  2  00 hold, 01 increment, 10 decrement, 11 load.
- i_pair_data  in  2*DATA_WIDTH  load value for op 11.
- o_pair_data  out  2*DATA_WIDTH  current value of selected pair (memory address).
- o_pair_wrap  out  1  registered one-cycle pulse on pair wrap-around.

## Operation
- Reads combinational: o_data_x = reg[addr] if en and addr < NUM_REGS, else 0. No write bypass: a write is visible the cycle after its edge.
- o_pair_data combinational = {reg[2k], reg[2k+1]}; shows pre-update value during the op cycle (post-increment semantics). Pair index with 2k >= NUM_REGS reads 0 and ignores ops.
- Byte write: reg[i_wr_addr] <= i_data; addresses >= NUM_REGS ignored.
- Pair op computed on the full 2*DATA_WIDTH value, modulo 2^(2*DATA_WIDTH); carry propagates low to high byte.
- Increment of all-ones -> 0, decrement of 0 -> all-ones: o_pair_wrap = 1 next cycle, else 0. Load and hold never set wrap.
- Collision: byte write targeting a byte of the selected pair in the same cycle as a non-hold op: byte write wins for that byte; the other byte takes the pair result. Wrap still reported from the pair computation.
- Byte write to a register outside the selected pair proceeds independently of any pair op.
- Ports A and B may address the same register; both return its value.

## Timing
- Reset (asserted low, async): all registers 0, o_pair_wrap 0; o_data_a/b and o_pair_data therefore 0 (subject to enables). Reset mid-operation discards the in-flight update.
- Deassertion synchronous to i_clk by the integration; first write accepted on first edge after release.
- Write and pair-op latency: 1 cycle. Read latency: 0 (combinational).
- o_pair_wrap: asserted exactly the cycle after the wrapping edge, cleared the following cycle unless another wrap occurs.
- Back-to-back ops on the same pair each act on the previous edge's result (e.g. three increments = +3).

## Test plan
- Reset then read all 8 registers on both ports with enables high -> all 0x00; enables low with nonzero contents -> 0x00.
- Write reg2=0x12, reg3=0xFF; select pair 1, op inc -> o_pair_data 0x12FF that cycle, 0x1300 next; o_pair_wrap stays 0.
- Pair 1 loaded 0xFFFF, inc -> 0x0000 with o_pair_wrap 1 for one cycle; dec from 0x0000 -> 0xFFFF, wrap 1.
- Pair 2 = 0x4000, dec with simultaneous byte write reg5=0xAA -> pair becomes 0x3FAA (high byte from dec, low from write).
- Write reg1=0x55 while reading reg1 on port A same cycle -> old value that cycle, 0x55 next; port B reg1 concurrently matches port A.
- Pair 0 mid-increment sequence, assert i_reset low between edges -> outputs 0 immediately; after release, inc yields 0x0001.

Source files
------------

// File: rtl/gb80_register_file_paired_if.sv
// Bus bundle for the paired gb80 register file: byte write port, two read
// ports, and the 16-bit pair port with its wrap flag.
interface gb80_register_file_paired_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                      i_wr_en;
   logic [ADDR_WIDTH-1:0]     i_wr_addr;
   logic [DATA_WIDTH-1:0]     i_data;
   logic                      i_rd_en_a;
   logic                      i_rd_en_b;
   logic [ADDR_WIDTH-1:0]     i_rd_addr_a;
   logic [ADDR_WIDTH-1:0]     i_rd_addr_b;
   logic [DATA_WIDTH-1:0]     o_data_a;
   logic [DATA_WIDTH-1:0]     o_data_b;
   logic [ADDR_WIDTH-2:0]     i_pair_sel;
   logic [1:0]                i_pair_op;
   logic [2*DATA_WIDTH-1:0]   i_pair_data;
   logic [2*DATA_WIDTH-1:0]   o_pair_data;
   logic                      o_pair_wrap;

   modport master (
      output i_wr_en, i_wr_addr, i_data,
      output i_rd_en_a, i_rd_en_b, i_rd_addr_a, i_rd_addr_b,
      output i_pair_sel, i_pair_op, i_pair_data,
      input  o_data_a, o_data_b, o_pair_data, o_pair_wrap
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_data,
      input  i_rd_en_a, i_rd_en_b, i_rd_addr_a, i_rd_addr_b,
      input  i_pair_sel, i_pair_op, i_pair_data,
      output o_data_a, o_data_b, o_pair_data, o_pair_wrap
   );
endinterface

// File: rtl/gb80_register_file_paired.sv
// Byte register bank with two zero-when-idle read ports, one byte write
// port and a 16-bit pair port with post-increment/decrement/load.
module gb80_register_file_paired #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned NUM_REGS   = 8
) (
   input logic i_clk,
   input logic i_reset,
   gb80_register_file_paired_if.slave bus
);
   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];
   localparam logic [PW-1:0] ONE = PW'(1);

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_LOAD = 2'b11
   } pair_op_e;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [ADDR_WIDTH-1:0] hi_idx;
   logic [ADDR_WIDTH-1:0] lo_idx;
   logic                  pair_valid;
   logic                  wr_valid;
   logic [PW-1:0]         pair_cur;
   logic [PW-1:0]         pair_next;
   logic                  wrap_next;
   logic                  wrap_q;
   pair_op_e              op;

   assign op         = pair_op_e'(bus.i_pair_op);
   assign hi_idx     = {bus.i_pair_sel, 1'b0};
   assign lo_idx     = {bus.i_pair_sel, 1'b1};
   assign pair_valid = ({1'b0, hi_idx} < NUM_REGS_W);
   assign wr_valid   = bus.i_wr_en && ({1'b0, bus.i_wr_addr} < NUM_REGS_W);

   // Read ports: zero when disabled or addressing an unimplemented register.
   always_comb begin
      bus.o_data_a = '0;
      bus.o_data_b = '0;
      if (bus.i_rd_en_a && ({1'b0, bus.i_rd_addr_a} < NUM_REGS_W))
         bus.o_data_a = regs[bus.i_rd_addr_a];
      if (bus.i_rd_en_b && ({1'b0, bus.i_rd_addr_b} < NUM_REGS_W))
         bus.o_data_b = regs[bus.i_rd_addr_b];
   end

   // Pair unit: current value, next value and wrap detection.
   always_comb begin
      pair_cur  = '0;
      pair_next = '0;
      wrap_next = 1'b0;
      if (pair_valid) begin
         pair_cur = {regs[hi_idx], regs[lo_idx]};
         unique case (op)
            OP_INC: begin
               pair_next = pair_cur + ONE;
               wrap_next = (pair_cur == '1);
            end
            OP_DEC: begin
               pair_next = pair_cur - ONE;
               wrap_next = (pair_cur == '0);
            end
            OP_LOAD: pair_next = bus.i_pair_data;
            default: pair_next = pair_cur;
         endcase
      end
   end

   assign bus.o_pair_data = pair_cur;
   assign bus.o_pair_wrap = wrap_q;

   // Register update; the byte write is scheduled after the pair update so it
   // overrides the colliding byte while the other byte keeps the pair result.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_next;
         if (pair_valid && (op != OP_HOLD)) begin
            regs[hi_idx] <= pair_next[PW-1:DATA_WIDTH];
            regs[lo_idx] <= pair_next[DATA_WIDTH-1:0];
         end
         if (wr_valid)
            regs[bus.i_wr_addr] <= bus.i_data;
      end
   end
endmodule
